// File: rtl/svm_pkg.sv
// Shared types and constants for the SVM inference batch controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package svm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        STREAM,
        WAIT_RES,
        EMIT,
        DONE
    } state_t;

    // Result class encodings presented on res_class
    localparam logic [1:0] CLS_POS = 2'b01;
    localparam logic [1:0] CLS_NEG = 2'b11;
    localparam logic [1:0] CLS_ERR = 2'b10;

    // Raw words the inference core returns for the two valid classes
    localparam logic [15:0] RES_POS = 16'h0001;
    localparam logic [15:0] RES_NEG = 16'hFFFF;

endpackage

// File: rtl/svm_feat_sequencer.sv
// Feature address generator: issues feature 0 in PRIME, then prefetches one address ahead while streaming.
// Latency: address is combinational from state; core_in_valid follows STREAM with no extra delay.
// Backpressure: none; the stream of NUM_FEAT words is never stalled once started.
module svm_feat_sequencer #(
    parameter int NUM_FEAT    = 8,
    parameter int MAX_SAMPLES = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  prime,
    input  logic                                  stream,
    input  logic [$clog2(MAX_SAMPLES)-1:0]        sample_idx,
    output logic [$clog2(MAX_SAMPLES*NUM_FEAT)-1:0] feat_addr,
    output logic                                  core_in_valid,
    output logic                                  last_feat
);

    localparam int AW = $clog2(MAX_SAMPLES*NUM_FEAT);
    localparam int FW = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;

    logic [FW-1:0] feat;
    logic [AW-1:0] base;

    // Feature counter advances once per streamed word and restarts for each sample
    always_ff @(posedge clk) begin
        if (rst || !stream) begin
            feat <= '0;
        end else begin
            feat <= feat + FW'(1);
        end
    end

    assign core_in_valid = stream;
    assign last_feat     = stream && (feat == FW'(NUM_FEAT - 1));
    assign base          = AW'(sample_idx) * AW'(NUM_FEAT);

    // Address one word ahead of the data currently on feat_rdata; hold on the last word
    // so the prefetch never runs past the end of the sample.
    always_comb begin
        feat_addr = '0;
        if (prime) begin
            feat_addr = base;
        end else if (stream) begin
            if (last_feat) begin
                feat_addr = base + AW'(feat);
            end else begin
                feat_addr = base + AW'(feat) + AW'(1);
            end
        end
    end

endmodule

// File: rtl/svm_infer_ctrl.sv
// Batch controller: streams NUM_FEAT features per sample into an SVM core and reports per-sample classes and tallies.
// Latency: first core_in_valid 2 cycles after accepted start; done pulses the cycle after the DONE state.
// Backpressure: EMIT holds res_valid until res_ready; optional result timeout via SVM_INFER_CTRL_TIMEOUT_EN.
module svm_infer_ctrl
    import svm_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_FEAT    = 8,
    parameter int MAX_SAMPLES = 16,
    parameter int TIMEOUT     = 255
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    start,
    input  logic [$clog2(MAX_SAMPLES+1)-1:0]        num_samples,
    output logic                                    busy,
    output logic                                    done,
    output logic [$clog2(MAX_SAMPLES*NUM_FEAT)-1:0] feat_addr,
    input  logic [DATA_WIDTH-1:0]                   feat_rdata,
    output logic [DATA_WIDTH-1:0]                   core_in,
    output logic                                    core_in_valid,
    input  logic [DATA_WIDTH-1:0]                   core_out,
    input  logic                                    core_outvalid,
    output logic [1:0]                              res_class,
    output logic [$clog2(MAX_SAMPLES)-1:0]          res_idx,
    output logic                                    res_valid,
    input  logic                                    res_ready,
    output logic [$clog2(MAX_SAMPLES+1)-1:0]        pos_count,
    output logic [$clog2(MAX_SAMPLES+1)-1:0]        neg_count,
    output logic [$clog2(MAX_SAMPLES+1)-1:0]        err_count
);

    localparam int CW = $clog2(MAX_SAMPLES+1);
    localparam int IW = $clog2(MAX_SAMPLES);
    localparam int TW = $clog2(TIMEOUT+1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic          last_feat;
    logic          last_sample;
    logic          timeout_hit;

    svm_feat_sequencer #(
        .NUM_FEAT    (NUM_FEAT),
        .MAX_SAMPLES (MAX_SAMPLES)
    ) u_seq (
        .clk           (clk),
        .rst           (rst),
        .prime         (state == PRIME),
        .stream        (state == STREAM),
        .sample_idx    (idx),
        .feat_addr     (feat_addr),
        .core_in_valid (core_in_valid),
        .last_feat     (last_feat)
    );

    // Memory data is passed straight through so the core sees it the cycle it arrives
    assign core_in     = core_in_valid ? feat_rdata : '0;
    assign res_valid   = (state == EMIT);
    assign res_idx     = idx;
    assign last_sample = (CW'(idx) == cnt - CW'(1));

`ifdef SVM_INFER_CTRL_TIMEOUT_EN
    logic [TW-1:0] wait_cnt;

    // Counts cycles spent in WAIT_RES, restarting on every entry
    always_ff @(posedge clk) begin
        if (rst || state != WAIT_RES) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + TW'(1);
        end
    end

    assign timeout_hit = (state == WAIT_RES) && (wait_cnt == TW'(TIMEOUT - 1));
`else
    logic [TW-1:0] unused_timeout;
    assign unused_timeout = TW'(TIMEOUT);
    assign timeout_hit    = 1'b0;
`endif

    // State register; reset wins over any start in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start) state_nxt = (num_samples == '0) ? DONE : PRIME;
            PRIME:    state_nxt = STREAM;
            STREAM:   if (last_feat) state_nxt = WAIT_RES;
            WAIT_RES: if (core_outvalid || timeout_hit) state_nxt = EMIT;
            EMIT:     if (res_ready) state_nxt = last_sample ? DONE : PRIME;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Batch bookkeeping: latched length, sample index, result class and tallies
    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            cnt       <= '0;
            idx       <= '0;
            res_class <= 2'b00;
            pos_count <= '0;
            neg_count <= '0;
            err_count <= '0;
        end else begin
            done <= (state == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt       <= (num_samples > CW'(MAX_SAMPLES)) ? CW'(MAX_SAMPLES) : num_samples;
                        idx       <= '0;
                        pos_count <= '0;
                        neg_count <= '0;
                        err_count <= '0;
                        busy      <= 1'b1;
                    end
                end
                WAIT_RES: begin
                    if (core_outvalid) begin
                        if (core_out == DATA_WIDTH'(RES_POS)) begin
                            res_class <= CLS_POS;
                            pos_count <= pos_count + CW'(1);
                        end else if (core_out == DATA_WIDTH'(RES_NEG)) begin
                            res_class <= CLS_NEG;
                            neg_count <= neg_count + CW'(1);
                        end else begin
                            res_class <= CLS_ERR;
                            err_count <= err_count + CW'(1);
                        end
                    end else if (timeout_hit) begin
                        res_class <= CLS_ERR;
                        err_count <= err_count + CW'(1);
                    end
                end
                EMIT: begin
                    if (res_ready) begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE: begin
                    busy <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_svm_infer_ctrl.sv
// Self-checking bench for svm_infer_ctrl with a memory model, a core model and a batch-level reference.
// Latency: checks first core_in_valid at 2 cycles, zero batch done at 2 cycles, result latency per core delay.
// Backpressure: res_ready is stalled per sample; the timeout scenario runs when SVM_INFER_CTRL_TIMEOUT_EN is defined.
module tb_svm_infer_ctrl;

    localparam int DW = 16;
    localparam int NF = 8;
    localparam int MS = 16;
    localparam int TO = 255;
    localparam int CW = $clog2(MS+1);
    localparam int AW = $clog2(MS*NF);
    localparam int IW = $clog2(MS);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] num_samples = '0;
    logic          busy, done;
    logic [AW-1:0] feat_addr;
    logic [DW-1:0] feat_rdata;
    logic [DW-1:0] core_in;
    logic          core_in_valid;
    logic [DW-1:0] core_out = '0;
    logic          core_outvalid = 1'b0;
    logic [1:0]    res_class;
    logic [IW-1:0] res_idx;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [CW-1:0] pos_count, neg_count, err_count;

    int n_pass = 0;
    int n_total = 0;

    logic [DW-1:0] mem [MS*NF];
    logic [DW-1:0] res_val [MS];
    int            res_dly [MS];
    int            stall   [MS];

    svm_infer_ctrl #(.DATA_WIDTH(DW), .NUM_FEAT(NF), .MAX_SAMPLES(MS), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .busy(busy), .done(done), .feat_addr(feat_addr), .feat_rdata(feat_rdata),
        .core_in(core_in), .core_in_valid(core_in_valid),
        .core_out(core_out), .core_outvalid(core_outvalid),
        .res_class(res_class), .res_idx(res_idx), .res_valid(res_valid), .res_ready(res_ready),
        .pos_count(pos_count), .neg_count(neg_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Synchronous-read feature memory: data one cycle after the address
    always @(posedge clk) feat_rdata <= mem[feat_addr];

    // Expected class of sample i: silent core means timeout error
    function automatic logic [1:0] exp_cls(input int i);
        if (res_dly[i] < 0) return 2'b10;
        if (res_val[i] == 16'h0001) return 2'b01;
        if (res_val[i] == 16'hFFFF) return 2'b11;
        return 2'b10;
    endfunction

    task automatic run_batch(input string name, input int n, input int abort_s, input bit junk);
        int  cyc, s, feat, cd, waitc, ep, en, ee, wr_start, first_valid;
        bit  done_seen, in_run, res_first;
        ep = 0; en = 0; ee = 0;
        for (int i = 0; i < n; i++) begin
            case (exp_cls(i))
                2'b01:   ep++;
                2'b11:   en++;
                default: ee++;
            endcase
        end
        @(negedge clk);
        start = 1'b1; num_samples = CW'(n);
        cyc = 0; s = 0; feat = 0; cd = -1; waitc = 0; wr_start = 0; first_valid = -1;
        done_seen = 0; in_run = 0; res_first = 0;
        @(negedge clk);
        start = 1'b0; cyc = 1;
        n_total++; if (busy !== 1'b1) $display("FAIL %s busy_after_start got %b want 1", name, busy); else n_pass++;
        for (int b = 0; b < 3000 && !done_seen; b++) begin
            core_outvalid = 1'b0; res_ready = 1'b0; start = 1'b0;
            if (core_in_valid) begin
                if (first_valid < 0) begin
                    first_valid = cyc;
                    n_total++; if (cyc != 2) $display("FAIL %s first_valid_cycle got %0d want 2", name, cyc); else n_pass++;
                end
                n_total++; if (core_in !== mem[s*NF+feat]) $display("FAIL %s core_in s%0d f%0d got %h want %h", name, s, feat, core_in, mem[s*NF+feat]); else n_pass++;
                if (feat < NF-1) begin
                    n_total++; if (feat_addr !== AW'(s*NF+feat+1)) $display("FAIL %s prefetch_addr got %0d want %0d", name, feat_addr, s*NF+feat+1); else n_pass++;
                end
                feat++; in_run = 1;
                if (abort_s == s && feat == 3) begin
                    rst = 1'b1;
                    @(negedge clk);
                    n_total++; if (core_in_valid !== 1'b0) $display("FAIL %s rst_valid got %b want 0", name, core_in_valid); else n_pass++;
                    n_total++; if (busy !== 1'b0 || done !== 1'b0 || res_valid !== 1'b0) $display("FAIL %s rst_flags got %b%b%b want 000", name, busy, done, res_valid); else n_pass++;
                    n_total++; if ({pos_count, neg_count, err_count} !== '0) $display("FAIL %s rst_counts got %0d/%0d/%0d want 0/0/0", name, pos_count, neg_count, err_count); else n_pass++;
                    n_total++; if (feat_addr !== '0) $display("FAIL %s rst_addr got %0d want 0", name, feat_addr); else n_pass++;
                    rst = 1'b0;
                    return;
                end
                if (junk && $urandom_range(0, 2) == 0) begin core_outvalid = 1'b1; core_out = 16'($urandom); end
            end else if (in_run) begin
                n_total++; if (feat != NF) $display("FAIL %s stream_len got %0d want %0d", name, feat, NF); else n_pass++;
                in_run = 0; cd = res_dly[s]; waitc = 0; wr_start = cyc; res_first = 1;
            end
            if (cd == 0) begin core_outvalid = 1'b1; core_out = res_val[s]; cd = -1; end
            else if (cd > 0) cd--;
            if (res_valid) begin
                if (res_first) begin
                    res_first = 0;
                    n_total++;
                    if (cyc - wr_start != ((res_dly[s] < 0) ? TO : res_dly[s] + 1))
                        $display("FAIL %s result_latency got %0d want %0d", name, cyc - wr_start, (res_dly[s] < 0) ? TO : res_dly[s] + 1);
                    else n_pass++;
                end
                n_total++; if (res_idx !== IW'(s)) $display("FAIL %s res_idx got %0d want %0d", name, res_idx, s); else n_pass++;
                n_total++; if (res_class !== exp_cls(s)) $display("FAIL %s res_class s%0d got %b want %b", name, s, res_class, exp_cls(s)); else n_pass++;
                if (waitc >= stall[s]) begin res_ready = 1'b1; s++; feat = 0; end
                else waitc++;
                if (junk && !core_outvalid) begin core_outvalid = 1'b1; core_out = 16'($urandom); end
            end
            if (junk && busy && $urandom_range(0, 3) == 0) begin start = 1'b1; num_samples = CW'($urandom_range(0, MS)); end
            if (done) begin
                done_seen = 1;
                n_total++; if (s != n) $display("FAIL %s results_emitted got %0d want %0d", name, s, n); else n_pass++;
                n_total++; if (busy !== 1'b0) $display("FAIL %s busy_at_done got %b want 0", name, busy); else n_pass++;
                n_total++; if (pos_count !== CW'(ep)) $display("FAIL %s pos_count got %0d want %0d", name, pos_count, ep); else n_pass++;
                n_total++; if (neg_count !== CW'(en)) $display("FAIL %s neg_count got %0d want %0d", name, neg_count, en); else n_pass++;
                n_total++; if (err_count !== CW'(ee)) $display("FAIL %s err_count got %0d want %0d", name, err_count, ee); else n_pass++;
                if (n == 0) begin
                    n_total++; if (cyc != 2) $display("FAIL %s zero_done_cycle got %0d want 2", name, cyc); else n_pass++;
                    n_total++; if (first_valid != -1) $display("FAIL %s zero_stream got valid at %0d want none", name, first_valid); else n_pass++;
                end
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        core_outvalid = 1'b0; res_ready = 1'b0; start = 1'b0;
        if (!done_seen) begin
            n_total++;
            $display("FAIL %s done_timeout got no done want done within 3000 cycles", name);
            rst = 1'b1; @(negedge clk); rst = 1'b0;
        end else begin
            @(negedge clk);
            n_total++; if (done !== 1'b0) $display("FAIL %s done_pulse_width got %b want 0", name, done); else n_pass++;
            n_total++; if (pos_count !== CW'(ep)) $display("FAIL %s pos_hold got %0d want %0d", name, pos_count, ep); else n_pass++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; num_samples = CW'(3);
        @(negedge clk); @(negedge clk);
        n_total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset busy_done got %b%b want 00", busy, done); else n_pass++;
        n_total++; if (core_in_valid !== 1'b0 || core_in !== '0) $display("FAIL reset core_in got %b/%h want 0/0", core_in_valid, core_in); else n_pass++;
        n_total++; if (res_valid !== 1'b0 || feat_addr !== '0) $display("FAIL reset res_addr got %b/%0d want 0/0", res_valid, feat_addr); else n_pass++;
        n_total++; if ({pos_count, neg_count, err_count} !== '0) $display("FAIL reset counts got %0d/%0d/%0d want 0/0/0", pos_count, neg_count, err_count); else n_pass++;
        rst = 1'b0; start = 1'b0;
        @(negedge clk); @(negedge clk);
        n_total++; if (busy !== 1'b0 || core_in_valid !== 1'b0) $display("FAIL reset_dominates_start got busy %b valid %b want 0 0", busy, core_in_valid); else n_pass++;
    endtask

    task automatic test_single();
        res_val[0] = 16'h0001; res_dly[0] = 5; stall[0] = 0;
        run_batch("single", 1, -1, 0);
    endtask

    task automatic test_back_to_back();
        res_val[0] = 16'h0001; res_dly[0] = 2; stall[0] = 0;
        res_val[1] = 16'hFFFF; res_dly[1] = 3; stall[1] = 4;
        res_val[2] = 16'h0001; res_dly[2] = 1; stall[2] = 0;
        run_batch("backpressure", 3, -1, 0);
    endtask

    task automatic test_zero();
        run_batch("zero", 0, -1, 0);
    endtask

    task automatic test_invalid();
        res_val[0] = 16'h1234; res_dly[0] = 0; stall[0] = 1;
        run_batch("invalid", 1, -1, 0);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin res_val[i] = 16'h0001; res_dly[i] = 1; stall[i] = 0; end
        run_batch("reset_mid", 3, 1, 0);
        res_val[0] = 16'hFFFF; res_val[1] = 16'h0001;
        run_batch("after_reset", 2, -1, 0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 4; t++) begin
            int n;
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 2))
                    0:       res_val[i] = 16'h0001;
                    1:       res_val[i] = 16'hFFFF;
                    default: res_val[i] = 16'($urandom);
                endcase
                res_dly[i] = $urandom_range(0, 6);
                stall[i]   = $urandom_range(0, 3);
            end
            run_batch("random", n, -1, 1);
        end
    endtask

`ifdef SVM_INFER_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        res_val[0] = 16'h0001; res_dly[0] = -1; stall[0] = 0;
        res_val[1] = 16'hFFFF; res_dly[1] = 2;  stall[1] = 0;
        run_batch("timeout", 2, -1, 0);
    endtask
`endif

    initial begin
        for (int i = 0; i < MS*NF; i++) mem[i] = 16'($urandom);
        for (int i = 0; i < MS; i++) begin res_val[i] = 16'h0001; res_dly[i] = 0; stall[i] = 0; end
        test_reset();
        test_single();
        test_back_to_back();
        test_zero();
        test_invalid();
        test_reset_mid();
        test_random();
`ifdef SVM_INFER_CTRL_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
